seven_segment_scan_controller: RTL and testbench

//  Time-multiplexes one shared 7-segment decoder across DIGITS common-cathode digits.

---
 rtl/seven_segment_scan_controller.sv | 177 +++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Scans DIGITS common-cathode digits through one shared decoder, with a blanking gap between slots
// and a double-buffered display value. Define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module seven_segment_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                load_valid,
  input  logic [4*DIGITS-1:0] load_data,
  output logic                load_ready,
  output logic [3:0]          code_out,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_done
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SHOW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [SHOW_W-1:0]   show_cnt, show_cnt_next;
  logic [BLANK_W-1:0]  blank_cnt, blank_cnt_next;
  logic [4*DIGITS-1:0] active, active_next;
  logic [4*DIGITS-1:0] pending, pending_next;
  logic                pending_full, pending_full_next;
  logic                apply;
  logic                frame_done_next;
  logic [3:0]          code_next;
  logic [DIGITS-1:0]   sel_next;
  logic [DIGITS-1:0]   dark_mask;

  function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] value,
                                        input logic [IDX_W-1:0] k);
    nibble = 4'(value >> (4 * k));
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      show_cnt     <= '0;
      blank_cnt    <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      load_ready   <= 1'b1;
      code_out     <= 4'd0;
      digit_sel    <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      show_cnt     <= show_cnt_next;
      blank_cnt    <= blank_cnt_next;
      active       <= active_next;
      pending      <= pending_next;
      pending_full <= pending_full_next;
      load_ready   <= ~pending_full_next;
      code_out     <= code_next;
      digit_sel    <= sel_next;
      frame_done   <= frame_done_next;
    end
  end

  // Pending is only ever copied to active while scanning is idle or at the frame wrap,
  // and a load can never coincide with that copy because ready is low whenever it is possible.
  always_comb begin
    state_next        = state;
    idx_next          = idx;
    show_cnt_next     = show_cnt;
    blank_cnt_next    = blank_cnt;
    active_next       = active;
    pending_next      = pending;
    pending_full_next = pending_full;
    frame_done_next   = 1'b0;
    apply             = 1'b0;

    if (load_valid && load_ready) begin
      pending_next      = load_data;
      pending_full_next = 1'b1;
    end

    if (!enable) begin
      state_next     = IDLE;
      idx_next       = '0;
      show_cnt_next  = '0;
      blank_cnt_next = '0;
      apply          = (state == IDLE) && pending_full;
    end else begin
      case (state)
        IDLE: begin
          state_next     = BLANK;
          idx_next       = '0;
          blank_cnt_next = '0;
          apply          = pending_full;
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            state_next    = SHOW;
            show_cnt_next = '0;
          end else begin
            blank_cnt_next = blank_cnt + BLANK_W'(1);
          end
        end
        SHOW: begin
          if (show_cnt == SHOW_LAST) begin
            state_next     = BLANK;
            blank_cnt_next = '0;
            if (idx == LAST_IDX) begin
              idx_next        = '0;
              frame_done_next = 1'b1;
              apply           = pending_full;
            end else begin
              idx_next = idx + IDX_W'(1);
            end
          end else begin
            show_cnt_next = show_cnt + SHOW_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (apply) begin
      active_next       = pending;
      pending_full_next = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Digit k goes dark when it and every more significant nibble are zero; digit 0 never does.
  always_comb begin
    dark_mask  = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above & (active_next[4*k +: 4] == 4'd0);
      dark_mask[k] = zero_above;
    end
  end
`else
  assign dark_mask = '0;
`endif

  // Outputs are decoded from the upcoming state so they leave the flops aligned with it.
  always_comb begin
    code_next = 4'd0;
    sel_next  = '0;
    case (state_next)
      BLANK: code_next = nibble(active_next, idx_next);
      SHOW: begin
        code_next = nibble(active_next, idx_next);
        sel_next  = (DIGITS'(1) << idx_next) & ~dark_mask;
      end
      default: begin
        code_next = 4'd0;
        sel_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomised scoreboard bench for seven_segment_scan_controller: expected lit slots come from a
// frame-level model of the display value; a negedge monitor pops and compares each lit segment.
module tb_seven_segment_scan_controller;

  localparam int D = 4;
  localparam int S = 4;
  localparam int B = 2;
  localparam int F = D * (S + B);
  localparam int NF = 20;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] code;
  } slot_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  code_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  slot_t       exp_q[$];
  bit          sb_on;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_pend_full;

  logic [3:0] seg_sel;
  logic [3:0] seg_code;
  int         seg_len;
  int         gap_len;
  int         fd_gap;
  bit         in_seg;
  bit         have_prev;
  bit         have_fd;
  bit         fd_prev;

  seven_segment_scan_controller #(
    .DIGITS      (D),
    .SHOW_CYCLES (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .code_out  (code_out),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue the lit slots a frame showing value v must produce, in scan order.
  task automatic push_frame(input logic [15:0] v);
    for (int k = 0; k < D; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (k >= 1 && (v >> (4 * k)) == 16'd0) continue;
`endif
      exp_q.push_back({4'(1 << k), 4'(v >> (4 * k))});
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] v);
    load_data  = v;
    load_valid = 1'b1;
    if (!m_pend_full) begin
      m_pend      = v;
      m_pend_full = 1'b1;
    end
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic wait_frame_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clock);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sel(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clock);
      if (digit_sel == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v = 16'($urandom);
    int z = $urandom_range(0, 3);
    return v >> (4 * z);
  endfunction

  task automatic close_segment();
    slot_t e;
    if (exp_q.size() == 0) begin
      check_output("unexpected_slot", int'(seg_sel), 0);
    end else begin
      e = exp_q.pop_front();
      check_output("slot_sel", int'(seg_sel), int'(e.sel));
      check_output("slot_code", int'(seg_code), int'(e.code));
      check_output("slot_len", seg_len, S);
    end
  endtask

  // Monitor: a lit segment is a run of identical nonzero digit_sel samples.
  initial begin
    forever begin
      @(negedge clock);
      if (!sb_on) begin
        in_seg    = 1'b0;
        have_prev = 1'b0;
        have_fd   = 1'b0;
        fd_prev   = 1'b0;
        gap_len   = 0;
        fd_gap    = 0;
      end else begin
        fd_gap++;
        if (frame_done) begin
          check_output("frame_done_width", int'(fd_prev), 0);
          if (have_fd) check_output("frame_period", fd_gap, F);
          have_fd = 1'b1;
          fd_gap  = 0;
        end
        fd_prev = frame_done;
        if (digit_sel != 4'd0) begin
          if (in_seg && digit_sel == seg_sel) begin
            seg_len++;
            check_output("code_stable", int'(code_out), int'(seg_code));
          end else begin
            if (in_seg) close_segment();
`ifndef LEADING_ZERO_BLANK_EN
            if (have_prev) check_output("blank_gap", gap_len, B);
`endif
            in_seg    = 1'b1;
            have_prev = 1'b1;
            seg_sel   = digit_sel;
            seg_code  = code_out;
            seg_len   = 1;
          end
          gap_len = 0;
        end else begin
          if (in_seg) begin
            close_segment();
            in_seg = 1'b0;
          end
          gap_len++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] fixed_vals[3];
    logic [15:0] v;
    bit ok;

    fixed_vals[0] = 16'hABCD;
    fixed_vals[1] = 16'h0005;
    fixed_vals[2] = 16'h0000;

    reset_n     = 1'b1;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_data   = 16'h0000;
    sb_on       = 1'b0;
    m_active    = 16'h0000;
    m_pend      = 16'h0000;
    m_pend_full = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_output("reset_sel", int'(digit_sel), 0);
    check_output("reset_code", int'(code_out), 0);
    check_output("reset_ready", int'(load_ready), 1);
    check_output("reset_frame_done", int'(frame_done), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Randomised scan with loads landing mid-frame
    sb_on = 1'b1;
    apply_stimulus(16'h4321);
    m_active    = m_pend;
    m_pend_full = 1'b0;
    push_frame(m_active);
    enable = 1'b1;
    for (int f = 0; f < NF; f++) begin
      wait_frame_done(ok);
      check_output("frame_done_seen", int'(ok), 1);
      if (!ok) break;
      if (m_pend_full) begin
        m_active    = m_pend;
        m_pend_full = 1'b0;
      end
      if (f == NF - 1) break;
      push_frame(m_active);
      @(negedge clock);
      check_output("ready_after_wrap", int'(load_ready), int'(!m_pend_full));
      repeat ($urandom_range(0, 6)) @(negedge clock);
      if (f < 3 || $urandom_range(0, 3) != 0) begin
        v = (f < 3) ? fixed_vals[f] : rand_value();
        check_output("ready_before_load", int'(load_ready), int'(!m_pend_full));
        apply_stimulus(v);
        @(negedge clock);
        check_output("ready_while_pending", int'(load_ready), int'(!m_pend_full));
        apply_stimulus(~v);
      end
    end
    @(negedge clock);
    sb_on = 1'b0;
    check_output("scoreboard_drained", exp_q.size(), 0);

    // Enable drop during digit 2, then restart from digit 0
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check_output("ready_idle", int'(load_ready), int'(!m_pend_full));
    apply_stimulus(16'h9876);
    m_active    = m_pend;
    m_pend_full = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    wait_sel(4'b0100, ok);
    check_output("reach_digit2", int'(ok), 1);
    enable = 1'b0;
    @(negedge clock);
    check_output("drop_sel", int'(digit_sel), 0);
    check_output("drop_code", int'(code_out), 0);
    repeat (3) @(negedge clock);
    check_output("drop_sel_hold", int'(digit_sel), 0);
    enable = 1'b1;
    for (int i = 0; i < B; i++) begin
      @(negedge clock);
      check_output("reblank_sel", int'(digit_sel), 0);
      check_output("reblank_code", int'(code_out), int'(m_active[3:0]));
    end
    @(negedge clock);
    check_output("restart_sel", int'(digit_sel), 1);
    check_output("restart_code", int'(code_out), int'(m_active[3:0]));

    // Asynchronous reset mid-SHOW with a pending value held
    check_output("ready_before_reset_load", int'(load_ready), int'(!m_pend_full));
    apply_stimulus(16'h1111);
    check_output("ready_pending_reset", int'(load_ready), int'(!m_pend_full));
    wait_sel(4'b0010, ok);
    check_output("reach_digit1", int'(ok), 1);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_sel", int'(digit_sel), 0);
    check_output("async_reset_code", int'(code_out), 0);
    check_output("async_reset_ready", int'(load_ready), 1);
    check_output("async_reset_frame_done", int'(frame_done), 0);
    enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // After reset the held value is gone: the display shows zeros
    m_active    = 16'h0000;
    m_pend_full = 1'b0;
    sb_on       = 1'b1;
    push_frame(m_active);
    @(negedge clock);
    enable = 1'b1;
    wait_frame_done(ok);
    check_output("post_reset_frame1", int'(ok), 1);
    push_frame(m_active);
    wait_frame_done(ok);
    check_output("post_reset_frame2", int'(ok), 1);
    @(negedge clock);
    sb_on = 1'b0;
    check_output("post_reset_drained", exp_q.size(), 0);

    enable = 1'b0;
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
